// File: rtl/uart_rx_fifo.sv
// Receive-side buffer between the UART receiver and the CPU bus: captures each
// completed frame with its error flags and queues it in a show-ahead FIFO.
module uart_rx_fifo #(
    parameter int ADDR_W       = 4,
    parameter int GUARD_CYCLES = 4
) (
    input  logic              clk16x,
    input  logic              clrn,
    input  logic              r_ready,
    input  logic [7:0]        rx_d,
    input  logic              rx_perr,
    input  logic              rx_ferr,
    output logic              rx_rdn,
    input  logic              cpu_rd,
    output logic [7:0]        cpu_data,
    output logic              cpu_perr,
    output logic              cpu_ferr,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_ovr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int GW    = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        GUARD
    } state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   gcnt, gcnt_nx;
    logic            perr_hold, ferr_hold;

    logic [9:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [9:0]        head;
    logic              push, push_ok, pop_ok, ovr_set;

    always_comb begin
        state_nx = state;
        gcnt_nx  = gcnt;
        case (state)
            IDLE: begin
                if (r_ready) state_nx = READ;
            end
            READ: begin
                state_nx = GUARD;
                gcnt_nx  = '0;
            end
            GUARD: begin
                // Any r_ready echo restarts the quiet-period count.
                if (r_ready) begin
                    gcnt_nx = '0;
                end else if (gcnt == GW'(GUARD_CYCLES - 1)) begin
                    gcnt_nx  = '0;
                    state_nx = IDLE;
                end else begin
                    gcnt_nx = gcnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The strobe lags the READ state by one edge, so the push lands on its closing edge.
    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            gcnt      <= '0;
            rx_rdn    <= 1'b1;
            perr_hold <= 1'b0;
            ferr_hold <= 1'b0;
        end else begin
            state  <= state_nx;
            gcnt   <= gcnt_nx;
            rx_rdn <= (state != READ);
            if (state == IDLE && r_ready) begin
                perr_hold <= rx_perr;
                ferr_hold <= rx_ferr;
            end
        end
    end

    assign push    = !rx_rdn;
    assign empty   = (count == '0);
    assign full    = count[ADDR_W];
    assign pop_ok  = cpu_rd && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign ovr_set = push && full && !pop_ok;

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk16x) begin
        if (push_ok) mem[wr_ptr] <= {ferr_hold, perr_hold, rx_d};
    end

    assign head     = mem[rd_ptr];
    assign cpu_data = head[7:0];
    assign cpu_perr = head[8];
    assign cpu_ferr = head[9];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed, table-driven bench for uart_rx_fifo with a simple receiver model.
module tb_uart_rx_fifo;

    logic       clk16x = 1'b0;
    logic       clrn = 1'b0;
    logic       r_ready = 1'b0;
    logic [7:0] rx_d = '0;
    logic       rx_perr = 1'b0;
    logic       rx_ferr = 1'b0;
    logic       rx_rdn;
    logic       cpu_rd = 1'b0;
    logic [7:0] cpu_data;
    logic       cpu_perr;
    logic       cpu_ferr;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       clr_ovr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    uart_rx_fifo #(.ADDR_W(4), .GUARD_CYCLES(4)) dut (
        .clk16x   (clk16x),
        .clrn     (clrn),
        .r_ready  (r_ready),
        .rx_d     (rx_d),
        .rx_perr  (rx_perr),
        .rx_ferr  (rx_ferr),
        .rx_rdn   (rx_rdn),
        .cpu_rd   (cpu_rd),
        .cpu_data (cpu_data),
        .cpu_perr (cpu_perr),
        .cpu_ferr (cpu_ferr),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .clr_ovr  (clr_ovr)
    );

    always #5 clk16x = ~clk16x;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_ovr;
    } vec_t;

    vec_t fill_tab [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver model: raise r_ready, drop it (and the flags) once rdn goes low.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic fe, input logic pop_with);
        int unsigned waited = 0;
        rx_d = d; rx_perr = pe; rx_ferr = fe; r_ready = 1'b1;
        @(negedge clk16x);
        while (rx_rdn && waited < 8) begin
            @(negedge clk16x);
            waited++;
        end
        chk("rdn_strobe", rx_rdn, 1'b0);
        r_ready = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
        if (pop_with) cpu_rd = 1'b1;
        @(negedge clk16x);
        cpu_rd = 1'b0;
        repeat (5) @(negedge clk16x);
    endtask

    task automatic pop();
        cpu_rd = 1'b1;
        @(negedge clk16x);
        cpu_rd = 1'b0;
    endtask

    logic pat [13];

    initial begin
        for (int i = 0; i < 17; i++) begin
            fill_tab[i].d         = (i == 16) ? 8'hFF : 8'(i);
            fill_tab[i].pe        = (i % 5 == 3);
            fill_tab[i].fe        = (i % 7 == 6);
            fill_tab[i].exp_count = (i >= 15) ? 5'd16 : 5'(i + 1);
            fill_tab[i].exp_full  = (i >= 15);
            fill_tab[i].exp_ovr   = (i == 16);
        end

        // Reset state
        #12;
        chk("rst_rdn", rx_rdn, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 5'd0);
        chk("rst_ovr", overrun, 1'b0);
        @(negedge clk16x);
        clrn = 1'b1;
        @(negedge clk16x);

        // Single byte with exact strobe timing
        rx_d = 8'hA5; r_ready = 1'b1;
        @(negedge clk16x);
        chk("lat_rdn_hi_after_E", rx_rdn, 1'b1);
        @(negedge clk16x);
        chk("lat_rdn_lo", rx_rdn, 1'b0);
        chk("lat_empty_during_read", empty, 1'b1);
        r_ready = 1'b0;
        @(negedge clk16x);
        chk("lat_rdn_hi_after", rx_rdn, 1'b1);
        chk("single_empty", empty, 1'b0);
        chk("single_count", count, 5'd1);
        chk("single_data", cpu_data, 8'hA5);
        chk("single_perr", cpu_perr, 1'b0);
        chk("single_ferr", cpu_ferr, 1'b0);
        repeat (5) @(negedge clk16x);
        chk("single_no_dup", count, 5'd1);
        pop();
        chk("single_pop_empty", empty, 1'b1);
        pop();
        chk("pop_empty_ignored", count, 5'd0);

        // Error flags
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        chk("err1_data", cpu_data, 8'h3C);
        chk("err1_perr", cpu_perr, 1'b1);
        chk("err1_ferr", cpu_ferr, 1'b0);
        pop();
        chk("err2_data", cpu_data, 8'h55);
        chk("err2_perr", cpu_perr, 1'b0);
        chk("err2_ferr", cpu_ferr, 1'b1);
        pop();
        chk("err_empty", empty, 1'b1);

        // Fill, overrun, drain
        for (int i = 0; i < 17; i++) begin
            send_frame(fill_tab[i].d, fill_tab[i].pe, fill_tab[i].fe, 1'b0);
            chk("fill_count", count, fill_tab[i].exp_count);
            chk("fill_full", full, fill_tab[i].exp_full);
            chk("fill_ovr", overrun, fill_tab[i].exp_ovr);
        end
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", cpu_data, fill_tab[i].d);
            chk("drain_perr", cpu_perr, fill_tab[i].pe);
            chk("drain_ferr", cpu_ferr, fill_tab[i].fe);
            pop();
            chk("drain_count", count, 5'(15 - i));
        end
        chk("drain_empty", empty, 1'b1);
        chk("ovr_sticky", overrun, 1'b1);
        clr_ovr = 1'b1;
        @(negedge clk16x);
        clr_ovr = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // Simultaneous push and pop at full
        for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        chk("sim_full", full, 1'b1);
        chk("sim_head_before", cpu_data, 8'h10);
        send_frame(8'h99, 1'b0, 1'b0, 1'b1);
        chk("sim_count", count, 5'd16);
        chk("sim_ovr", overrun, 1'b0);
        chk("sim_head_after", cpu_data, 8'h11);
        for (int i = 0; i < 15; i++) begin
            chk("sim_drain", cpu_data, 8'(8'h11 + i));
            pop();
        end
        chk("sim_tail", cpu_data, 8'h99);
        chk("sim_tail_count", count, 5'd1);
        pop();
        chk("sim_empty", empty, 1'b1);

        // Duplicate guard: echoes of r_ready must not re-trigger a read
        pat = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
        rx_d = 8'h77; r_ready = 1'b1;
        begin
            int unsigned waited = 0;
            @(negedge clk16x);
            while (rx_rdn && waited < 8) begin
                @(negedge clk16x);
                waited++;
            end
        end
        chk("dup_first_rdn", rx_rdn, 1'b0);
        for (int k = 0; k < 13; k++) begin
            r_ready = pat[k];
            if (k == 11) rx_d = 8'h78;
            @(negedge clk16x);
            chk("dup_rdn", rx_rdn, (k == 12) ? 1'b0 : 1'b1);
            if (k == 10) chk("dup_one_push", count, 5'd1);
        end
        r_ready = 1'b0;
        @(negedge clk16x);
        chk("dup_count", count, 5'd2);
        chk("dup_head", cpu_data, 8'h77);
        pop();
        chk("dup_second", cpu_data, 8'h78);
        pop();
        repeat (5) @(negedge clk16x);

        // Reset in the READ cycle with three entries stored
        send_frame(8'h01, 1'b0, 1'b0, 1'b0);
        send_frame(8'h02, 1'b0, 1'b0, 1'b0);
        send_frame(8'h03, 1'b0, 1'b0, 1'b0);
        chk("rstmid_count3", count, 5'd3);
        rx_d = 8'hEE; r_ready = 1'b1;
        @(negedge clk16x);
        @(negedge clk16x);
        chk("rstmid_in_read", rx_rdn, 1'b0);
        clrn = 1'b0;
        #1;
        chk("rstmid_rdn", rx_rdn, 1'b1);
        chk("rstmid_count", count, 5'd0);
        chk("rstmid_empty", empty, 1'b1);
        chk("rstmid_ovr", overrun, 1'b0);
        r_ready = 1'b0;
        @(negedge clk16x);
        clrn = 1'b1;
        @(negedge clk16x);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("post_rst_count", count, 5'd1);
        chk("post_rst_data", cpu_data, 8'h5A);
        chk("post_rst_ferr", cpu_ferr, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiver and the CPU bus, clocked by the same x16 baud clock. It detects a completed frame via the receiver's `r_ready`, captures the error flags, and issues a one-cycle active-low read strobe to fetch the byte. It stores byte plus flags in a circular FIFO and presents a show-ahead read port with occupancy and sticky overrun status. This decouples CPU read latency from the line rate.

## Interface

**Parameters**
- `ADDR_W`, default 4: FIFO address width; depth = 2^ADDR_W entries.
- `GUARD_CYCLES`, default 4: consecutive clk16x cycles with `r_ready` low required before re-arming.

**Ports**
- `clk16x`  in  1: baud x16 clock; all logic is rising-edge.
- `clrn`  in  1: reset, asynchronous, active-low.
- `r_ready`  in  1: receiver frame-ready flag.
- `rx_d`  in  8: receiver data bus; valid only while `rx_rdn` = 0.
- `rx_perr`  in  1: receiver parity_error.
- `rx_ferr`  in  1: receiver frame_error.
- `rx_rdn`  out  1: read strobe to receiver, active-low, registered.
- `cpu_rd`  in  1: pop request, one-cycle synchronous pulse.
- `cpu_data`  out  8: data at the head entry.
- `cpu_perr`  out  1: parity flag of the head entry.
- `cpu_ferr`  out  1: frame flag of the head entry.
- `empty`  out  1: FIFO holds 0 entries.
- `full`  out  1: FIFO holds 2^ADDR_W entries.
- `count`  out  ADDR_W+1: occupancy.
- `overrun`  out  1: sticky; a byte was dropped because the FIFO was full.
- `clr_ovr`  in  1: synchronous clear of `overrun`.

## Operation

**Capture FSM**, states IDLE, READ, GUARD.
- IDLE: `rx_rdn` = 1. If `r_ready` = 1:
  - latch `rx_perr` and `rx_ferr` into hold registers. The flags must be captured here, because the receiver clears them when `rdn` goes low.
  - go to READ.
- READ: `rx_rdn` = 0 for exactly one cycle. At the closing edge:
  - capture `rx_d`.
  - push {ferr_hold, perr_hold, rx_d}.
  - go to GUARD.
- GUARD: `rx_rdn` = 1. A guard counter increments each cycle `r_ready` = 0 and resets to 0 when `r_ready` = 1.
  - When it reaches GUARD_CYCLES, return to IDLE.
  - Purpose: the receiver may re-assert `r_ready` for a cycle or two after the frame. The guard prevents a duplicate push.

**FIFO**
- Entry is 10 bits: {ferr, perr, data}.
- `wr_ptr` and `rd_ptr` are ADDR_W bits and wrap modulo 2^ADDR_W.
- `count` is tracked explicitly, range 0..2^ADDR_W.
- Head entry is shown without a pop (show-ahead): `cpu_data`/`cpu_perr`/`cpu_ferr` = mem[rd_ptr].
- When `empty` = 1, these outputs are don't-care; the bench must not check them.

**Push and pop rules**
- Push when not full: write, `wr_ptr`+1, `count`+1.
- Push when full and no pop in the same cycle: entry discarded, pointers unchanged, `overrun` ← 1.
- Push when full with a simultaneous pop: push accepted, no overrun, `count` unchanged.
- Pop (`cpu_rd` = 1) when not empty: `rd_ptr`+1, `count`−1.
- Pop when empty: ignored, no state change.
- Simultaneous push and pop when not empty: both performed, `count` unchanged.
- Simultaneous push and pop when empty: push only; the pop is ignored.

**Overrun**
- Sticky until `clr_ovr` = 1.
- If set and clear occur in the same cycle, set wins.

**Flags**
- `empty` = (`count` == 0).
- `full` = (`count` == 2^ADDR_W).
- Both are derived combinationally from the registered `count`.

## Timing

**Reset** (`clrn` = 0, asynchronous)
- FSM → IDLE, `rx_rdn` = 1.
- Pointers, `count`, guard counter, and hold flags → 0.
- `overrun` = 0, `empty` = 1, `full` = 0.
- Memory contents are not reset.
- Reset during READ: `rx_rdn` returns to 1 immediately, no push occurs, the byte is lost.

**Capture latency**
- `r_ready` first sampled high at edge E.
- `rx_rdn` low from edge E+1 to edge E+2.
- Entry written at edge E+2; `count`/`empty` update after edge E+2.
- Earliest valid `cpu_data` is in the cycle following E+2.

**Pop**
- `cpu_rd` sampled at edge P; the head advances after P.
- New head data is valid in the cycle after P.

**Minimum spacing**
- Spacing between captures is 2 + GUARD_CYCLES cycles.
- This is far below one frame (≥176 clk16x cycles), so every byte is accepted.

## Test plan

- **Single byte:** receiver delivers 0xA5 with no errors.
  - `rx_rdn` low for exactly 1 cycle, 1 cycle after `r_ready` is seen.
  - `empty` 1→0, `count` = 1, `cpu_data` = 0xA5, `cpu_perr` = `cpu_ferr` = 0.
  - `cpu_rd` pulse → `empty` = 1.
- **Error flags:** frame 0x3C with `rx_perr` = 1, then frame 0x55 with `rx_ferr` = 1.
  - Head shows 0x3C / perr = 1 / ferr = 0.
  - After a pop, head shows 0x55 / perr = 0 / ferr = 1.
- **Fill and wrap:** push 16 bytes 0x00..0x0F, no pops.
  - `full` = 1, `count` = 16.
  - 17th byte 0xFF → `overrun` = 1, `count` stays 16.
  - Pop all 16 → sequence is 0x00..0x0F, `empty` = 1.
  - `clr_ovr` → `overrun` = 0.
- **Simultaneous at full:** FIFO full; `cpu_rd` pulses on the same edge as the READ push.
  - `count` stays 16, `overrun` stays 0.
  - Last popped entry is the old head; new byte is at the tail.
- **Duplicate guard:** hold `r_ready` high for 3 cycles after the first `rx_rdn` pulse, then low.
  - Exactly one push.
  - No second `rx_rdn` until `r_ready` has been low 4 consecutive cycles.
- **Reset mid-operation:** assert `clrn` low in the READ cycle with 3 entries stored.
  - `rx_rdn` = 1 immediately, `count` = 0, `empty` = 1, `overrun` = 0.
  - Next frame after reset is captured normally.
